// File: rtl/dbg_capture_pkg.sv
// Shared types and default sizing for the MII debug capture block.
package dbg_capture_pkg;

  localparam int DEF_NUM_CH   = 4;
  localparam int DEF_CH_W     = 8;
  localparam int DEF_DEPTH    = 256;
  localparam int DEF_PRE_TRIG = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_ARMED,
    ST_POST,
    ST_DONE,
    ST_READ
  } state_t;

  // Width of the channel-select field; a single channel still needs one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dbg_capture_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
// The array itself carries no reset; only the read register holds state.
module dbg_capture_ram #(
  parameter int DEPTH = 256,
  parameter int W     = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_rdata;

  // Write port: store one probe sample per enabled cycle.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read port: one-cycle latency, output holds while i_re is low.
  always_ff @(posedge clk) begin
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mii_debug_capture.sv
// Triggered logic-analyser style capture of a multi-channel probe bus.
// Captures PRE_TRIG samples before the trigger and fills the rest of the
// DEPTH-entry buffer after it, then streams the window out oldest-first.
module mii_debug_capture
  import dbg_capture_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int CH_W     = DEF_CH_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int PRE_TRIG = DEF_PRE_TRIG
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_CH*CH_W-1:0]         probe_in,
  input  logic                           arm,
  input  logic                           abort,
  input  logic [sel_width(NUM_CH)-1:0]   trig_sel,
  input  logic [CH_W-1:0]                trig_value,
  input  logic [CH_W-1:0]                trig_mask,
  input  logic                           ext_en,
  input  logic                           ext_trig,
  input  logic                           rd_ready,
  output logic [NUM_CH*CH_W-1:0]         rd_data,
  output logic                           rd_valid,
  output logic                           rd_last,
  output logic                           armed,
  output logic                           triggered,
  output logic                           done
);

  localparam int W      = NUM_CH * CH_W;
  localparam int AW     = $clog2(DEPTH);
  localparam int SW     = sel_width(NUM_CH);
  localparam int POST_N = DEPTH - PRE_TRIG - 1;

  localparam logic [AW-1:0] PRE_LAST  = AW'((PRE_TRIG > 0) ? PRE_TRIG - 1 : 0);
  localparam logic [AW-1:0] POST_LAST = AW'((POST_N > 0) ? POST_N - 1 : 0);
  localparam logic [AW-1:0] PRE_OFS   = AW'(PRE_TRIG);
  localparam logic [AW-1:0] RD_PENULT = AW'(DEPTH - 2);

  state_t        r_state;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_trig_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_cnt;
  logic          r_rd_valid;
  logic          r_rd_last;
  logic          r_armed;
  logic          r_triggered;
  logic          r_done;

  logic [CH_W-1:0] w_trig_ch;
  logic            w_trig_hit;
  logic            w_capturing;
  logic            w_xfer;
  logic            w_rd_re;
  logic [AW-1:0]   w_rd_addr;
  logic [W-1:0]    w_ram_q;

  // Select the trigger channel; an out-of-range select falls back to channel 0.
  always_comb begin
    w_trig_ch = probe_in[CH_W-1:0];
    for (int k = 0; k < NUM_CH; k++) begin
      if (trig_sel == SW'(k)) w_trig_ch = probe_in[k*CH_W +: CH_W];
    end
  end

  assign w_trig_hit  = (((w_trig_ch ^ trig_value) & trig_mask) == '0) || (ext_en && ext_trig);
  assign w_capturing = (r_state == ST_PRE) || (r_state == ST_ARMED) || (r_state == ST_POST);

  // Read side: fetch the first sample on READ entry, then prefetch the next
  // address on every transfer so rd_data updates without a bubble. A stall
  // disables the read so the RAM output register holds the presented sample.
  assign w_xfer    = (r_state == ST_READ) && r_rd_valid && rd_ready;
  assign w_rd_re   = (r_state == ST_READ) && (!r_rd_valid || rd_ready);
  assign w_rd_addr = w_xfer ? r_rd_ptr + 1'b1 : r_rd_ptr;

  dbg_capture_ram #(
    .DEPTH (DEPTH),
    .W     (W),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_capturing),
    .i_waddr (r_wr_ptr),
    .i_wdata (probe_in),
    .i_re    (w_rd_re),
    .i_raddr (w_rd_addr),
    .o_rdata (w_ram_q)
  );

  // Capture/readout state machine with registered status flags; abort wins over everything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_wr_ptr    <= '0;
      r_trig_ptr  <= '0;
      r_rd_ptr    <= '0;
      r_cnt       <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_last   <= 1'b0;
      r_armed     <= 1'b0;
      r_triggered <= 1'b0;
      r_done      <= 1'b0;
    end else if (abort) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_last   <= 1'b0;
      r_armed     <= 1'b0;
      r_triggered <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      if (w_capturing) r_wr_ptr <= r_wr_ptr + 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (arm) begin
            r_cnt <= '0;
            if (PRE_TRIG == 0) begin
              r_state <= ST_ARMED;
              r_armed <= 1'b1;
            end else begin
              r_state <= ST_PRE;
            end
          end
        end
        ST_PRE: begin
          if (r_cnt == PRE_LAST) begin
            r_cnt   <= '0;
            r_state <= ST_ARMED;
            r_armed <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_ARMED: begin
          if (w_trig_hit) begin
            r_trig_ptr  <= r_wr_ptr;
            r_armed     <= 1'b0;
            r_triggered <= 1'b1;
            r_cnt       <= '0;
            if (POST_N == 0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_POST;
            end
          end
        end
        ST_POST: begin
          if (r_cnt == POST_LAST) begin
            r_cnt   <= '0;
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          r_rd_ptr <= r_trig_ptr - PRE_OFS;
          r_cnt    <= '0;
          r_done   <= 1'b0;
          r_state  <= ST_READ;
        end
        ST_READ: begin
          if (!r_rd_valid) begin
            r_rd_valid <= 1'b1;
            r_rd_last  <= 1'b0;
          end else if (rd_ready) begin
            if (r_rd_last) begin
              r_state     <= ST_IDLE;
              r_rd_valid  <= 1'b0;
              r_rd_last   <= 1'b0;
              r_triggered <= 1'b0;
            end else begin
              r_rd_ptr  <= r_rd_ptr + 1'b1;
              r_cnt     <= r_cnt + 1'b1;
              r_rd_last <= (r_cnt == RD_PENULT);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rd_data   = r_rd_valid ? w_ram_q : '0;
  assign rd_valid  = r_rd_valid;
  assign rd_last   = r_rd_last;
  assign armed     = r_armed;
  assign triggered = r_triggered;
  assign done      = r_done;

endmodule

// File: tb/tb_mii_debug_capture.sv
// Bench for mii_debug_capture: directed table, multi-cycle abort/reset
// sequences and randomized captures against a window-slicing model.
module tb_mii_debug_capture;

  localparam int NUM_CH   = 4;
  localparam int CH_W     = 8;
  localparam int DEPTH    = 16;
  localparam int PRE_TRIG = 4;
  localparam int POST_N   = DEPTH - PRE_TRIG - 1;
  localparam int W        = NUM_CH * CH_W;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] probe_in;
  logic         arm, abort;
  logic [1:0]   trig_sel;
  logic [7:0]   trig_value, trig_mask;
  logic         ext_en, ext_trig, rd_ready;
  logic [W-1:0] rd_data;
  logic         rd_valid, rd_last, armed, triggered, done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] ramp;
  logic [7:0] chan_off [NUM_CH];

  always #5 clk = ~clk;

  mii_debug_capture #(
    .NUM_CH   (NUM_CH),
    .CH_W     (CH_W),
    .DEPTH    (DEPTH),
    .PRE_TRIG (PRE_TRIG)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .probe_in   (probe_in),
    .arm        (arm),
    .abort      (abort),
    .trig_sel   (trig_sel),
    .trig_value (trig_value),
    .trig_mask  (trig_mask),
    .ext_en     (ext_en),
    .ext_trig   (ext_trig),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_last    (rd_last),
    .armed      (armed),
    .triggered  (triggered),
    .done       (done)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] probe_word(input logic [7:0] r);
    logic [W-1:0] w;
    for (int k = 0; k < NUM_CH; k++) w[k*CH_W +: CH_W] = r + chan_off[k];
    return w;
  endfunction

  // Trigger rule applied to a logged sample and the ext_trig level seen with it.
  function automatic bit model_hit(input logic [W-1:0] s, input bit e);
    logic [7:0] ch;
    ch = s[int'(trig_sel)*CH_W +: CH_W];
    return (((ch ^ trig_value) & trig_mask) == 8'h00) || (ext_en && e);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    ramp = ramp + 8'd1;
    probe_in = probe_word(ramp);
  endtask

  // One full capture + readout. ext_mode: 0 none, 1 pulse at log index ext_idx,
  // 2 random. rdy_mode: 0 always ready, 1 alternating, 2 random.
  task automatic run_capture(input logic [7:0] start, input int ext_mode, input int ext_idx,
                             input int rdy_mode, output logic [7:0] first_c0, output logic [7:0] last_c0);
    logic [W-1:0] log_q[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] held;
    logic         held_last;
    int           trig_idx, idx, n;
    bit           e;
    first_c0 = 8'hxx;
    last_c0  = 8'hxx;
    ramp = start;
    probe_in = probe_word(ramp);
    rd_ready = 1'b0;
    arm = 1'b1;
    step();
    arm = 1'b0;
    trig_idx = -1;
    idx = 0;
    forever begin
      if (ext_mode == 1)      e = (idx == ext_idx);
      else if (ext_mode == 2) e = ($urandom_range(0, 31) == 0);
      else                    e = 1'b0;
      ext_trig = e;
      if (idx == PRE_TRIG) check("armed_flag", {63'd0, armed}, 64'd1);
      log_q.push_back(probe_in);
      if (trig_idx < 0 && idx >= PRE_TRIG && model_hit(probe_in, e)) trig_idx = idx;
      step();
      if (trig_idx >= 0 && idx == trig_idx + POST_N) break;
      idx++;
      if (idx > 800) begin
        check("trigger_timeout", 64'd0, 64'd1);
        ext_trig = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        return;
      end
    end
    ext_trig = 1'b0;
    check("status_done", {61'd0, armed, triggered, done}, 64'd3);
    for (int i = trig_idx - PRE_TRIG; i <= trig_idx + POST_N; i++) exp_q.push_back(log_q[i]);
    step();
    check("rd_valid_on_read_entry", {63'd0, rd_valid}, 64'd0);
    step();
    check("rd_valid_one_after_entry", {63'd0, rd_valid}, 64'd1);
    n = 0;
    for (int cyc = 0; cyc < 200 && n < DEPTH; cyc++) begin
      case (rdy_mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = (cyc % 2 == 0);
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      if (rd_valid && rd_ready) begin
        check($sformatf("rd_data[%0d]", n), {32'd0, rd_data}, {32'd0, exp_q[n]});
        check($sformatf("rd_last[%0d]", n), {63'd0, rd_last}, {63'd0, (n == DEPTH - 1)});
        if (n == 0) first_c0 = rd_data[7:0];
        if (n == DEPTH - 1) last_c0 = rd_data[7:0];
        n++;
        step();
      end else if (rd_valid) begin
        held = rd_data;
        held_last = rd_last;
        step();
        check("stall_hold", {30'd0, rd_valid, rd_last, rd_data}, {30'd0, 1'b1, held_last, held});
      end else begin
        step();
      end
    end
    if (n < DEPTH) check("read_timeout", 64'(n), 64'(DEPTH));
    rd_ready = 1'b0;
    check("idle_after_last", {62'd0, rd_valid, triggered}, 64'd0);
  endtask

  typedef struct {
    logic [1:0] sel;
    logic [7:0] val;
    logic [7:0] mask;
    logic       ext;
    int         ext_mode;
    int         ext_idx;
    int         rdy_mode;
    logic [7:0] start;
    logic [7:0] exp_first;
    logic [7:0] exp_last;
  } vec_t;

  initial begin
    vec_t       tbl[5];
    logic [7:0] f, l;
    bit         bad;

    tbl[0] = '{2'd0, 8'h20, 8'hFF, 1'b0, 0, 0,            0, 8'h00, 8'h1C, 8'h2B};
    tbl[1] = '{2'd0, 8'h20, 8'hFF, 1'b0, 0, 0,            0, 8'h1E, 8'h1C, 8'h2B};
    tbl[2] = '{2'd0, 8'h20, 8'hFF, 1'b0, 0, 0,            1, 8'h00, 8'h1C, 8'h2B};
    tbl[3] = '{2'd0, 8'h00, 8'hFF, 1'b1, 1, PRE_TRIG + 6, 0, 8'h40, 8'h47, 8'h56};
    tbl[4] = '{2'd1, 8'h55, 8'h00, 1'b0, 0, 0,            2, 8'h80, 8'h81, 8'h90};

    for (int k = 0; k < NUM_CH; k++) chan_off[k] = 8'h00;
    reset_n = 1'b0;
    arm = 1'b0; abort = 1'b0; ext_en = 1'b0; ext_trig = 1'b0; rd_ready = 1'b0;
    trig_sel = 2'd0; trig_value = 8'h00; trig_mask = 8'hFF;
    ramp = 8'h00;
    probe_in = probe_word(ramp);
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {27'd0, rd_data, rd_valid, rd_last, armed, triggered, done}, 64'd0);
    reset_n = 1'b1;

    // Reset asserted in the middle of POST, then a normal capture.
    trig_mask = 8'h00;
    arm = 1'b1;
    step();
    arm = 1'b0;
    repeat (PRE_TRIG + 3) step();
    check("pre_reset_triggered", {63'd0, triggered}, 64'd1);
    reset_n = 1'b0;
    #2;
    check("async_reset_outputs", {27'd0, rd_data, rd_valid, rd_last, armed, triggered, done}, 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step();
    check("post_reset_idle", {61'd0, armed, triggered, done}, 64'd0);

    // Directed table.
    for (int t = 0; t < 5; t++) begin
      trig_sel = tbl[t].sel;
      trig_value = tbl[t].val;
      trig_mask = tbl[t].mask;
      ext_en = tbl[t].ext;
      run_capture(tbl[t].start, tbl[t].ext_mode, tbl[t].ext_idx, tbl[t].rdy_mode, f, l);
      check($sformatf("vec%0d_first", t), {56'd0, f}, {56'd0, tbl[t].exp_first});
      check($sformatf("vec%0d_last", t), {56'd0, l}, {56'd0, tbl[t].exp_last});
      ext_en = 1'b0;
    end

    // Abort together with arm in IDLE: arm must be dropped.
    trig_mask = 8'h00;
    arm = 1'b1;
    abort = 1'b1;
    step();
    arm = 1'b0;
    abort = 1'b0;
    repeat (PRE_TRIG) step();
    check("abort_beats_arm", {62'd0, armed, triggered}, 64'd0);

    // Abort in the same cycle as a trigger match.
    arm = 1'b1;
    step();
    arm = 1'b0;
    repeat (PRE_TRIG) step();
    check("armed_before_abort", {63'd0, armed}, 64'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_beats_trigger", {61'd0, armed, triggered, done}, 64'd0);

    // Abort on the third POST cycle.
    arm = 1'b1;
    step();
    arm = 1'b0;
    repeat (PRE_TRIG + 3) step();
    check("in_post_before_abort", {61'd0, armed, triggered, done}, 64'd2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_clears", {60'd0, armed, triggered, done, rd_valid}, 64'd0);
    bad = 1'b0;
    rd_ready = 1'b1;
    repeat (20) begin
      step();
      if (done || rd_valid || triggered) bad = 1'b1;
    end
    rd_ready = 1'b0;
    check("abort_stays_idle", {63'd0, bad}, 64'd0);

    // Re-arm after abort.
    trig_sel = 2'd0; trig_value = 8'h20; trig_mask = 8'hFF;
    run_capture(8'h00, 0, 0, 0, f, l);
    check("rearm_first", {56'd0, f}, 64'h1C);

    // Randomized captures with distinct per-channel offsets.
    for (int it = 0; it < 6; it++) begin
      for (int k = 0; k < NUM_CH; k++) chan_off[k] = 8'($urandom);
      trig_sel = 2'($urandom_range(0, 3));
      trig_value = 8'($urandom);
      trig_mask = 8'($urandom);
      ext_en = 1'($urandom_range(0, 1));
      run_capture(8'($urandom), 2, 0, 2, f, l);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
